// File: rtl/lab_sysinfo_pkg.sv
// Shared constants and types for the system-info Avalon-MM slave.
package lab_sysinfo_pkg;

  localparam logic [2:0] ADDR_ID         = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP  = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO  = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_HI  = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH    = 3'd4;
  localparam logic [2:0] ADDR_HB_DIV     = 3'd5;
  localparam logic [2:0] ADDR_READ_COUNT = 3'd6;
  localparam logic [2:0] ADDR_RSVD       = 3'd7;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_pipe_t;

endpackage

// File: rtl/lab_sysinfo_rdpipe.sv
// Fixed-latency read-return pipeline: DEPTH-stage shift register of read results.
module lab_sysinfo_rdpipe
  import lab_sysinfo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  rd_pipe_t in_i,
  output rd_pipe_t out_o
);

  rd_pipe_t stage_q [DEPTH];

  // NOTE: every stage is reset, not just the valid bits, so a flushed pipe never leaks stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/lab_sysinfo_slave.sv
// System-info slave: ID/timestamp, 64-bit uptime with coherent HI shadow,
// byte-writable scratch, read counter and programmable heartbeat.
module lab_sysinfo_slave
  import lab_sysinfo_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h5C62_A0C1,
  parameter int          READ_LATENCY = 2,
  parameter int          UPTIME_W     = 64,
  parameter logic [31:0] HB_RESET_DIV = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        heartbeat
);

  logic [UPTIME_W-1:0] uptime_q, uptime_d;
  logic [63:0]         uptime_ext;
  logic [31:0]         shadow_q, shadow_d;
  logic [31:0]         scratch_q, scratch_d;
  logic [31:0]         hb_div_q, hb_div_d;
  logic [31:0]         hb_cnt_q, hb_cnt_d;
  logic                hb_q, hb_d;
  logic [31:0]         rd_count_q, rd_count_d;
  logic [31:0]         rd_word;
  logic                rd_accept;
  logic                hb_wr;
  rd_pipe_t            pipe_in, pipe_out;

  // A simultaneous write wins; the read is dropped entirely.
  assign rd_accept  = read & ~write;
  assign hb_wr      = write && (address == ADDR_HB_DIV);
  assign uptime_d   = uptime_q + UPTIME_W'(1);
  assign uptime_ext = 64'(uptime_q);

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_ID:         rd_word = ID_VALUE;
      ADDR_TIMESTAMP:  rd_word = TIMESTAMP;
      ADDR_UPTIME_LO:  rd_word = uptime_ext[31:0];
      ADDR_UPTIME_HI:  rd_word = shadow_q;
      ADDR_SCRATCH:    rd_word = scratch_q;
      ADDR_HB_DIV:     rd_word = hb_div_q;
      ADDR_READ_COUNT: rd_word = rd_count_q;
      default:         rd_word = '0;
    endcase
  end

  // NOTE: all next-state values get a default first, so no path through this block infers a latch.
  always_comb begin
    scratch_d  = scratch_q;
    hb_div_d   = hb_div_q;
    shadow_d   = shadow_q;
    rd_count_d = rd_count_q + 32'(rd_accept);
    hb_cnt_d   = hb_cnt_q;
    hb_d       = hb_q;

    if (write && (address == ADDR_SCRATCH)) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
    end
    if (hb_wr) hb_div_d = writedata;

    // Latch the high half alongside the LO read so a LO-then-HI pair is coherent.
    if (rd_accept && (address == ADDR_UPTIME_LO)) shadow_d = uptime_ext[63:32];

    if (hb_wr || (hb_div_q == '0)) begin
      hb_cnt_d = '0;
      hb_d     = 1'b0;
    end else if (hb_cnt_q == hb_div_q) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end else begin
      hb_cnt_d = hb_cnt_q + 32'd1;
    end

    pipe_in.valid = rd_accept;
    pipe_in.data  = rd_accept ? rd_word : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only; the _d values are settled before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_q   <= '0;
      shadow_q   <= '0;
      scratch_q  <= '0;
      hb_div_q   <= HB_RESET_DIV;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      rd_count_q <= '0;
    end else begin
      uptime_q   <= uptime_d;
      shadow_q   <= shadow_d;
      scratch_q  <= scratch_d;
      hb_div_q   <= hb_div_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      rd_count_q <= rd_count_d;
    end
  end

  lab_sysinfo_rdpipe #(.DEPTH(READ_LATENCY)) u_rdpipe (
    .clock (clock),
    .reset (reset),
    .in_i  (pipe_in),
    .out_o (pipe_out)
  );

  assign readdata      = pipe_out.data;
  assign readdatavalid = pipe_out.valid;
  assign heartbeat     = hb_q;

endmodule

// File: tb/tb_lab_sysinfo_slave.sv
// Self-checking bench for lab_sysinfo_slave: behavioural register-map model plus directed literals.
module tb_lab_sysinfo_slave;

  localparam logic [31:0] ID_VALUE  = 32'h1A2B_3C4D;
  localparam logic [31:0] TIMESTAMP = 32'h5C62_A0C1;
  localparam int          RD_LAT    = 2;
  localparam int          UPTIME_W  = 64;
  localparam logic [31:0] HB_RESET  = 32'd0;

  logic        clock, reset;
  logic [2:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid, heartbeat;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;
  logic force_active = 1'b0;
  logic [63:0] force_val = '0;

  lab_sysinfo_slave #(
    .ID_VALUE(ID_VALUE), .TIMESTAMP(TIMESTAMP), .READ_LATENCY(RD_LAT),
    .UPTIME_W(UPTIME_W), .HB_RESET_DIV(HB_RESET)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .heartbeat(heartbeat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { longint unsigned due; logic [31:0] data; } rd_t;
  rd_t              m_q[$];
  longint unsigned  m_e, m_hb_edges;
  logic [63:0]      m_upt, m_mask;
  logic [31:0]      m_shadow, m_scratch, m_div, m_rcount, m_word;
  logic             exp_valid, exp_hb;
  logic [31:0]      exp_data;

  task automatic model_reset();
    m_q.delete();
    m_e = 0; m_hb_edges = 0; m_upt = '0;
    m_mask = (UPTIME_W >= 64) ? '1 : ((64'd1 << UPTIME_W) - 64'd1);
    m_shadow = '0; m_scratch = '0; m_div = HB_RESET; m_rcount = '0;
    exp_valid = 1'b0; exp_data = '0; exp_hb = 1'b0;
  endtask

  task automatic model_step();
    m_e++;
    if (read && !write) begin
      case (address)
        3'd0: m_word = ID_VALUE;
        3'd1: m_word = TIMESTAMP;
        3'd2: m_word = m_upt[31:0];
        3'd3: m_word = m_shadow;
        3'd4: m_word = m_scratch;
        3'd5: m_word = m_div;
        3'd6: m_word = m_rcount;
        default: m_word = '0;
      endcase
      m_q.push_back('{due: m_e + RD_LAT - 1, data: m_word});
      m_rcount++;
      if (address == 3'd2) m_shadow = m_upt[63:32];
    end
    if (write && address == 3'd4)
      for (int b = 0; b < 4; b++) if (byteenable[b]) m_scratch[8*b +: 8] = writedata[8*b +: 8];
    if (write && address == 3'd5) begin
      m_div = writedata;
      m_hb_edges = 0;
    end else begin
      m_hb_edges++;
    end
    m_upt = force_active ? force_val : ((m_upt + 64'd1) & m_mask);
    exp_valid = 1'b0; exp_data = '0;
    if (m_q.size() > 0 && m_q[0].due == m_e) begin
      exp_valid = 1'b1;
      exp_data  = m_q[0].data;
      void'(m_q.pop_front());
    end
    exp_hb = (m_div == 0) ? 1'b0 : 1'(((m_hb_edges / (64'(m_div) + 64'd1)) % 2));
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  always @(negedge clock) begin
    if (!reset && chk_en) begin
      check("readdatavalid", 32'(readdatavalid), 32'(exp_valid));
      check("readdata", readdata, exp_data);
      check("heartbeat", 32'(heartbeat), 32'(exp_hb));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; read = 1'b0; write = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic read_lit(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clock);
    read = 1'b1; write = 1'b0; address = a;
    @(negedge clock);
    read = 1'b0;
    repeat (RD_LAT - 1) @(negedge clock);
    check({name, "_valid"}, 32'(readdatavalid), 32'd1);
    check(name, readdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_rdv", 32'(readdatavalid), 32'd0);
    check("reset_rdata", readdata, 32'd0);
    check("reset_hb", 32'(heartbeat), 32'd0);
    chk_en = 1'b1;

    // Back-to-back reads of ID, TIMESTAMP, reserved.
    @(negedge clock); read = 1'b1; address = 3'd0;
    @(negedge clock); address = 3'd1;
    check("t1_rdv_early", 32'(readdatavalid), 32'd0);
    @(negedge clock); address = 3'd7;
    check("t1_id_valid", 32'(readdatavalid), 32'd1);
    check("t1_id", readdata, ID_VALUE);
    @(negedge clock); read = 1'b0;
    check("t1_ts", readdata, TIMESTAMP);
    @(negedge clock);
    check("t1_rsvd_valid", 32'(readdatavalid), 32'd1);
    check("t1_rsvd", readdata, 32'd0);
    @(negedge clock);
    check("t1_rdv_done", 32'(readdatavalid), 32'd0);

    // Byte-enabled scratch write and ignored RO write.
    wr(3'd4, 32'hFFFF_FFFF, 4'b0101);
    read_lit(3'd4, 32'h00FF_00FF, "t2_scratch");
    wr(3'd0, 32'h0000_1234, 4'hF);
    read_lit(3'd0, ID_VALUE, "t2_id_ro");

    // Coherent uptime pair across the 32-bit carry.
    do_reset();
    @(negedge clock);
    force_val = 64'h0000_0000_FFFF_FFFF; force_active = 1'b1;
    force dut.uptime_d = 64'h0000_0000_FFFF_FFFF;
    @(posedge clock); #1;
    release dut.uptime_d;
    force_active = 1'b0;
    @(negedge clock); read = 1'b1; address = 3'd2;
    @(negedge clock); address = 3'd3;
    @(negedge clock); read = 1'b0;
    check("t3_lo_carry", readdata, 32'hFFFF_FFFF);
    @(negedge clock);
    check("t3_hi_carry", readdata, 32'h0000_0000);
    @(negedge clock); read = 1'b1; address = 3'd2;
    @(negedge clock); address = 3'd3;
    @(negedge clock); read = 1'b0;
    @(negedge clock);
    check("t3_hi_after", readdata, 32'h0000_0001);

    // Heartbeat with divider 3, then disabled.
    wr(3'd5, 32'd3, 4'hF);
    for (int i = 0; i < 16; i++) begin
      check("t4_hb_div3", 32'(heartbeat), 32'((i / 4) % 2));
      @(negedge clock);
    end
    wr(3'd5, 32'd0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      check("t4_hb_off", 32'(heartbeat), 32'd0);
      @(negedge clock);
    end

    // Simultaneous read and write: write wins, read dropped.
    do_reset();
    read_lit(3'd6, 32'd0, "t5_count0");
    @(negedge clock);
    read = 1'b1; write = 1'b1; address = 3'd4; writedata = 32'hA5A5_5A5A; byteenable = 4'hF;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_rdv", 32'(readdatavalid), 32'd0);
      @(negedge clock);
    end
    read_lit(3'd6, 32'd1, "t5_count1");
    read_lit(3'd4, 32'hA5A5_5A5A, "t5_scratch");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      read       = ($urandom_range(0, 3) != 0);
      write      = ($urandom_range(0, 5) == 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = (address == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom;
      byteenable = 4'($urandom_range(0, 15));
    end
    @(negedge clock); read = 1'b0; write = 1'b0;
    repeat (8) @(negedge clock);

    // Reset with reads outstanding: pipeline flushed.
    @(negedge clock); read = 1'b1; address = 3'd0;
    @(negedge clock); address = 3'd1;
    #2 reset = 1'b1;
    check("t6_rdv_in_reset", 32'(readdatavalid), 32'd0);
    @(negedge clock); read = 1'b0;
    check("t6_rdata_in_reset", readdata, 32'd0);
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t6_rdv_after", 32'(readdatavalid), 32'd0);
      check("t6_rdata_after", readdata, 32'd0);
      check("t6_hb_after", 32'(heartbeat), 32'd0);
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
